// File: rtl/minesweeper_pkg.sv
// Shared minesweeper definitions: board geometry, bomb-count codes from the
// switch encoder, generator state encoding and the code decoder.
package minesweeper_pkg;

  localparam int N_CELLS = 64;
  localparam int IDX_W   = 6;
  localparam int CNT_W   = 7;

  localparam logic [IDX_W-1:0] CODE_2  = 6'b000010;
  localparam logic [IDX_W-1:0] CODE_4  = 6'b000100;
  localparam logic [IDX_W-1:0] CODE_8  = 6'b001000;
  localparam logic [IDX_W-1:0] CODE_16 = 6'b010000;
  localparam logic [IDX_W-1:0] CODE_32 = 6'b100000;
  localparam logic [IDX_W-1:0] CODE_63 = 6'b111111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_PLACE,
    ST_DONE
  } gen_state_t;

  typedef struct packed {
    logic             valid;
    logic [CNT_W-1:0] target;
  } decode_t;

  // Anything outside the six one-hot/all-ones codes is rejected, including zero.
  function automatic decode_t decode_code(input logic [IDX_W-1:0] code);
    decode_t d;
    d.valid  = 1'b1;
    d.target = '0;
    case (code)
      CODE_2:  d.target = 7'd2;
      CODE_4:  d.target = 7'd4;
      CODE_8:  d.target = 7'd8;
      CODE_16: d.target = 7'd16;
      CODE_32: d.target = 7'd32;
      CODE_63: d.target = 7'd63;
      default: d.valid  = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lfsr_16.sv
// Free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1 (mask 16'hB400).
module lfsr_16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] value
);

  localparam logic [15:0] MASK = 16'hB400;

  logic [15:0] value_q;
  logic [15:0] value_d;

  always_comb begin
    value_d = value_q >> 1;
    if (value_q[0]) value_d = value_d ^ MASK;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) value_q <= SEED;
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/bomb_field_generator.sv
// Places a decoded number of bombs on the 8x8 board by LFSR-seeded linear
// probing, never on the safe cell, behind a start/busy/done handshake.
module bomb_field_generator
  import minesweeper_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [IDX_W-1:0]   bomb_code,
  input  logic [IDX_W-1:0]   safe_cell,
  output logic               busy,
  output logic               done,
  output logic               code_err,
  output logic [N_CELLS-1:0] bomb_map,
  output logic [CNT_W-1:0]   bomb_count
);

  gen_state_t         state_q, state_d;
  logic [N_CELLS-1:0] map_q, map_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   target_q, target_d;
  logic [IDX_W-1:0]   safe_q, safe_d;
  logic [IDX_W-1:0]   probe_q, probe_d;
  logic               err_q, err_d;

  logic [15:0] lfsr_value;
  logic        unused_lfsr_hi;
  decode_t     dec;

  lfsr_16 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr_value)
  );

  assign unused_lfsr_hi = ^lfsr_value[15:IDX_W];
  assign dec            = decode_code(bomb_code);

  // NOTE: every next-state signal is defaulted to its current value first, so
  // no path through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    map_d    = map_q;
    count_d  = count_q;
    target_d = target_q;
    safe_d   = safe_q;
    probe_d  = probe_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (dec.valid) begin
            target_d = dec.target;
            safe_d   = safe_cell;
            err_d    = 1'b0;
            state_d  = ST_CLEAR;
          end else begin
            err_d   = 1'b1;
            map_d   = '0;
            count_d = '0;
            state_d = ST_DONE;
          end
        end
      end
      ST_CLEAR: begin
        map_d   = '0;
        count_d = '0;
        probe_d = lfsr_value[IDX_W-1:0];
        state_d = ST_PLACE;
      end
      ST_PLACE: begin
        // Occupied or safe cell: step to the neighbour; a free cell always
        // exists because the target never exceeds N_CELLS-1.
        if (!map_q[probe_q] && (probe_q != safe_q)) begin
          map_d[probe_q] = 1'b1;
          count_d        = count_q + 7'd1;
          probe_d        = lfsr_value[IDX_W-1:0];
          if (count_d == target_q) state_d = ST_DONE;
        end else begin
          probe_d = probe_q + 6'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      map_q    <= '0;
      count_q  <= '0;
      target_q <= '0;
      safe_q   <= '0;
      probe_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      map_q    <= map_d;
      count_q  <= count_d;
      target_q <= target_d;
      safe_q   <= safe_d;
      probe_q  <= probe_d;
      err_q    <= err_d;
    end
  end

  assign busy       = (state_q == ST_CLEAR) || (state_q == ST_PLACE);
  assign done       = (state_q == ST_DONE);
  assign code_err   = err_q;
  assign bomb_map   = map_q;
  assign bomb_count = count_q;

endmodule
